// File: rtl/jtag_dr_pkg.sv
// Shared constants and length classification for the JTAG user data register bank.
package jtag_dr_pkg;

  localparam int unsigned DEF_WIDTH  = 32;
  localparam int unsigned DEF_NUM_CH = 4;

  // Stored alongside the channel index; marks a scan whose update must be dropped.
  localparam logic CH_INVALID = 1'b1;

  typedef enum logic [1:0] {LEN_OK, LEN_SHORT, LEN_LONG} len_status_e;

  function automatic len_status_e len_classify(input int unsigned cnt, input int unsigned width);
    if (cnt < width)       return LEN_SHORT;
    else if (cnt == width) return LEN_OK;
    else                   return LEN_LONG;
  endfunction

endpackage

// File: rtl/jtag_dr_shifter.sv
// Capture/shift data register with a saturating bit counter; LSB leaves first on tdo.
module jtag_dr_shifter
  import jtag_dr_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             tck_i,
  input  logic             rst_ni,
  input  logic             capture,
  input  logic             shift,
  input  logic [WIDTH-1:0] cap_val,
  input  logic             tdi,
  output logic             tdo,
  output logic [WIDTH-1:0] data,
  output logic             len_ok
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH + 1);

  logic [WIDTH-1:0] shift_q;
  logic [CNT_W-1:0] cnt_q;

  // Pause-DR needs no logic: neither capture nor shift is active, so state holds.
  always_ff @(posedge tck_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (capture) begin
      shift_q <= cap_val;
      cnt_q   <= '0;
    end else if (shift) begin
      shift_q <= {tdi, shift_q[WIDTH-1:1]};
      if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tdo    = shift_q[0];
  assign data   = shift_q;
  assign len_ok = (len_classify(32'(cnt_q), WIDTH) == LEN_OK);

endmodule

// File: rtl/jtag_dr_bank.sv
// Bank of NUM_CH selectable JTAG user data registers with length-checked update strobes.
module jtag_dr_bank
  import jtag_dr_pkg::*;
#(
  parameter  int unsigned WIDTH      = DEF_WIDTH,
  parameter  int unsigned NUM_CH     = DEF_NUM_CH,
  parameter  bit          STRICT_LEN = 1'b1,
  localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    tck_i,
  input  logic                    rst_ni,
  input  logic                    select_i,
  input  logic [CH_W-1:0]         ch_i,
  input  logic                    capture_dr_i,
  input  logic                    shift_dr_i,
  input  logic                    pause_dr_i,
  input  logic                    update_dr_i,
  input  logic                    tdi_i,
  output logic                    tdo_o,
  input  logic [NUM_CH*WIDTH-1:0] cap_data_i,
  output logic [NUM_CH*WIDTH-1:0] upd_data_o,
  output logic [NUM_CH-1:0]       upd_stb_o,
  output logic                    len_err_o
);

  logic [NUM_CH-1:0][WIDTH-1:0] cap_arr, upd_q;
  logic [WIDTH-1:0] cap_sel, shift_data;
  logic [CH_W-1:0]  ch_q;
  logic             ch_inv_q;
  logic             capture, shift, update, ch_ok, len_ok, len_fit, accept, len_rej;

  assign capture = select_i & capture_dr_i;
  assign shift   = select_i & shift_dr_i;
  assign update  = select_i & update_dr_i;
  assign cap_arr = cap_data_i;
  assign ch_ok   = (32'(ch_i) < NUM_CH);

  always_comb begin
    cap_sel = '0;
    for (int k = 0; k < int'(NUM_CH); k++)
      if (ch_i == CH_W'(k)) cap_sel = cap_arr[k];
  end

  jtag_dr_shifter #(.WIDTH(WIDTH)) u_shifter (
    .tck_i   (tck_i),
    .rst_ni  (rst_ni),
    .capture (capture),
    .shift   (shift),
    .cap_val (ch_ok ? cap_sel : '0),
    .tdi     (tdi_i),
    .tdo     (tdo_o),
    .data    (shift_data),
    .len_ok  (len_ok)
  );

  always_ff @(posedge tck_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ch_q     <= '0;
      ch_inv_q <= ~CH_INVALID;
    end else if (capture) begin
      ch_q     <= ch_i;
      ch_inv_q <= ch_ok ? ~CH_INVALID : CH_INVALID;
    end
  end

  // A bad channel drops the update silently; only length faults are flagged.
  assign len_fit = !STRICT_LEN || len_ok;
  assign accept  = update && (ch_inv_q != CH_INVALID) && len_fit;
  assign len_rej = update && (ch_inv_q != CH_INVALID) && !len_fit;

  always_ff @(posedge tck_i or negedge rst_ni) begin
    if (!rst_ni) begin
      upd_q     <= '0;
      upd_stb_o <= '0;
      len_err_o <= 1'b0;
    end else begin
      upd_stb_o <= '0;
      if (accept) begin
        upd_q[ch_q]     <= shift_data;
        upd_stb_o[ch_q] <= 1'b1;
        len_err_o       <= 1'b0;
      end else if (len_rej) begin
        len_err_o <= 1'b1;
      end
    end
  end

  assign upd_data_o = upd_q;

  logic unused;
  assign unused = pause_dr_i;

endmodule
